// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - writeback stage bundle: memory-stage handshake, dmem response, regfile write port
interface wb_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd_addr;
    logic            in_wen;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic [2:0]      in_addr_lo;
    logic [XLEN-1:0] in_result;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic [4:0]      rd_addr;
    logic            write_en;
    logic [XLEN-1:0] rd;
    logic            commit;
    logic [63:0]     instret;

    modport slave (
        input  in_valid, in_rd_addr, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
        input  dmem_rvalid, dmem_rdata,
        output in_ready, rd_addr, write_en, rd, commit, instret
    );

    modport master (
        output in_valid, in_rd_addr, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
        output dmem_rvalid, dmem_rdata,
        input  in_ready, rd_addr, write_en, rd, commit, instret
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load align/extend, regfile write, retire count (WB_INSTRET_EN)
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_if.slave     bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [4:0]      hold_rd_q;
    logic            hold_wen_q;
    logic [2:0]      hold_f3_q;
    logic [2:0]      hold_lo_q;
    logic [4:0]      rd_addr_q;
    logic            write_en_q;
    logic [XLEN-1:0] rd_q;
    logic            commit_q;

    logic            accept;
    logic            mem_done;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;

    assign bus.in_ready = (state_q != S_WAIT_MEM);
    assign accept       = bus.in_valid & bus.in_ready;
    assign mem_done     = (state_q == S_WAIT_MEM) & bus.dmem_rvalid;

    // Logical shift: bytes pulled in from above bit 63 read as zero.
    assign shifted = bus.dmem_rdata >> {hold_lo_q, 3'b000};

    always_comb begin
        load_val = shifted;
        case (hold_f3_q)
            3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_MEM: if (bus.dmem_rvalid) state_d = S_WRITE;
            S_IDLE, S_WRITE: begin
                if (accept) state_d = bus.in_is_load ? S_WAIT_MEM : S_WRITE;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_rd_q  <= '0;
            hold_wen_q <= 1'b0;
            hold_f3_q  <= '0;
            hold_lo_q  <= '0;
            rd_addr_q  <= '0;
            write_en_q <= 1'b0;
            rd_q       <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_en_q <= 1'b0;
            commit_q   <= 1'b0;
            if (accept) begin
                hold_rd_q  <= bus.in_rd_addr;
                hold_wen_q <= bus.in_wen;
                hold_f3_q  <= bus.in_funct3;
                hold_lo_q  <= bus.in_addr_lo;
            end
            // Accept and memory completion are exclusive: no accept while in WAIT_MEM.
            if (accept && !bus.in_is_load) begin
                rd_addr_q  <= bus.in_rd_addr;
                rd_q       <= bus.in_result;
                write_en_q <= bus.in_wen & (bus.in_rd_addr != 5'd0);
                commit_q   <= 1'b1;
            end else if (mem_done) begin
                rd_addr_q  <= hold_rd_q;
                rd_q       <= load_val;
                write_en_q <= hold_wen_q & (hold_rd_q != 5'd0);
                commit_q   <= 1'b1;
            end
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.write_en = write_en_q;
    assign bus.rd       = rd_q;
    assign bus.commit   = commit_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instret_q <= '0;
        else if (commit_q) instret_q <= instret_q + 64'd1;
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;
    logic clk;
    logic rst_n;

    wb_stage_if #(.XLEN(64)) bus ();

    wb_stage #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        wen;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    longint unsigned exp_retired = 0;

    function automatic logic [63:0] load_model(input logic [63:0] d, input logic [2:0] f3,
                                               input logic [2:0] lo);
        logic [63:0] w;
        int          nbits;
        logic        sgn;
        w = '0;
        for (int i = 0; i < 8; i++)
            if (i + int'(lo) < 8) w[8*i +: 8] = d[8*(i + int'(lo)) +: 8];
        if (f3[1:0] == 2'b11) return w;
        nbits = 8 << f3[1:0];
        sgn   = !f3[2] && w[nbits-1];
        for (int b = 0; b < 64; b++)
            if (b >= nbits) w[b] = sgn;
        return w;
    endfunction

    function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
        return exp_retired;
`else
        return 64'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.commit) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_commit: got commit=1 rd_addr=%0d rd=%h, expected commit=0",
                             bus.rd_addr, bus.rd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({bus.rd_addr, bus.write_en, bus.rd} !== {e.addr, e.wen, e.data}) begin
                        miscompares++;
                        $display("FAIL writeback: got addr=%0d wen=%b rd=%h, expected addr=%0d wen=%b rd=%h",
                                 bus.rd_addr, bus.write_en, bus.rd, e.addr, e.wen, e.data);
                    end
                end
            end else if (bus.write_en) begin
                vectors++;
                miscompares++;
                $display("FAIL write_without_commit: got write_en=1 commit=0, expected write_en=0");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_accept(input logic [4:0] rda, input logic wen, input logic ld,
                                input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] res);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_rd_addr = rda;
        bus.in_wen     = wen;
        bus.in_is_load = ld;
        bus.in_funct3  = f3;
        bus.in_addr_lo = lo;
        bus.in_result  = res;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_accept: got %b, expected 1", bus.in_ready);
        end
        if (!ld) begin
            sb.push_back('{rda, wen && (rda != 5'd0), res});
            exp_retired++;
        end
        @(posedge clk);
    endtask

    task automatic do_load(input logic [4:0] rda, input logic [2:0] f3, input logic [2:0] lo,
                           input logic [63:0] data, input int delay);
        drive_accept(rda, 1'b1, 1'b1, f3, lo, {$urandom, $urandom});
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL in_ready_wait: got %b, expected 0", bus.in_ready);
            end
            if (i == delay - 1) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = data;
                sb.push_back('{rda, rda != 5'd0, load_model(data, f3, lo)});
                exp_retired++;
            end
            @(negedge clk);
        end
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = {$urandom, $urandom};
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: got %0d outstanding writes, expected 0", name, sb.size());
        end
        vectors++;
        if (bus.instret !== exp_instret()) begin
            miscompares++;
            $display("FAIL %s_instret: got %0d, expected %0d", name, bus.instret, exp_instret());
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_rd_addr  = '0;
        bus.in_wen      = 1'b0;
        bus.in_is_load  = 1'b0;
        bus.in_funct3   = '0;
        bus.in_addr_lo  = '0;
        bus.in_result   = '0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.write_en, bus.commit, bus.rd_addr, bus.rd, bus.instret} !==
            {1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got ready=%b wen=%b commit=%b addr=%0d rd=%h instret=%0d, expected 1 0 0 0 0 0",
                     bus.in_ready, bus.write_en, bus.commit, bus.rd_addr, bus.rd, bus.instret);
        end
        rst_n = 1'b1;
        exp_retired = 0;
    endtask

    task automatic test_single();
        drive_accept(5'd5, 1'b1, 1'b0, 3'b0, 3'b0, 64'h1234);
        idle_check("single");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++)
            drive_accept(5'(i), 1'b1, 1'b0, 3'($urandom), 3'($urandom), 64'h100 + 64'(i));
        idle_check("back_to_back");
    endtask

    task automatic test_loads();
        do_load(5'd7, 3'b000, 3'd3, 64'h0000_0000_8000_0000, 4);
        vectors++;
        if (load_model(64'h0000_0000_8000_0000, 3'b000, 3'd3) !== 64'hFFFF_FFFF_FFFF_FF80) begin
            miscompares++;
            $display("FAIL model_lb: model disagrees with expected FFFFFFFFFFFFFF80");
        end
        do_load(5'd8, 3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 2);
        do_load(5'd9, 3'b110, 3'd6, 64'hBEEF_0000_0000_0000, 1);
        for (int f = 0; f < 8; f++)
            do_load(5'(10 + f), 3'(f), 3'($urandom), {$urandom, $urandom}, 1 + int'($urandom_range(0, 3)));
        do_load(5'd20, 3'b011, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 1);
        drive_accept(5'd21, 1'b1, 1'b0, 3'b0, 3'b0, 64'h55);
        idle_check("loads");
    endtask

    task automatic test_x0();
        drive_accept(5'd0, 1'b1, 1'b0, 3'b0, 3'b0, 64'hFFFF);
        drive_accept(5'd4, 1'b0, 1'b0, 3'b0, 3'b0, 64'hAAAA);
        do_load(5'd0, 3'b011, 3'd0, 64'h1, 2);
        idle_check("x0");
    endtask

    task automatic test_stray_rvalid();
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        vectors++;
        if (bus.commit !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid: got commit=%b, expected 0", bus.commit);
        end
        idle_check("stray");
    endtask

    task automatic test_reset_mid_load();
        drive_accept(5'd12, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 64'h1234_5678;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        vectors++;
        if ({bus.write_en, bus.commit, bus.in_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_mid_load: got wen=%b commit=%b ready=%b, expected 0 0 1",
                     bus.write_en, bus.commit, bus.in_ready);
        end
        idle_check("reset_mid_load");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_loads();
        test_x0();
        test_stray_rvalid();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
